// File: rtl/goc_pwm_tx_pkg.sv
// Shared types and defaults for the GOC pulse-width-modulated transmitter.
package goc_pwm_tx_pkg;

    // Default timing-unit width and symbol shape.
    localparam int DEF_SPEED_W    = 22;
    localparam int DEF_UNITS_SYM  = 4;
    localparam int DEF_UNITS_ONE  = 3;
    localparam int DEF_UNITS_ZERO = 1;
    localparam int DEF_STOP_UNITS = 8;

    // Level driven on the pad whenever no high phase is in progress.
    localparam logic PWM_IDLE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SYM_HIGH = 3'd2,
        ST_SYM_LOW  = 3'd3,
        ST_STOP     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Unit counter width: must count 0..max(sym,stop)-1, never narrower than 3 bits.
    function automatic int unit_cnt_width(input int units_sym, input int stop_units);
        int m;
        int w;
        m = (units_sym > stop_units) ? units_sym : stop_units;
        w = $clog2(m);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/goc_pwm_tx_unit_timer.sv
// Timing-unit generator: pulses unit_tick once every unit_len clocks while enabled.
module goc_pwm_tx_unit_timer #(
    parameter int SPEED_W = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic [SPEED_W-1:0] unit_len,
    output logic               unit_tick
);

    localparam logic [SPEED_W-1:0] LEN_ONE = SPEED_W'(1);

    logic [SPEED_W-1:0] cnt_q;
    logic [SPEED_W-1:0] cnt_d;

    // Down-counter reloads to unit_len-1 on a tick, when idle, or when the phase changes.
    always_comb begin
        unit_tick = en && (cnt_q == '0);
        if (clear || !en || unit_tick) begin
            cnt_d = unit_len - LEN_ONE;
        end else begin
            cnt_d = cnt_q - LEN_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/goc_pwm_tx.sv
// GOC optical PWM serialiser: pops bytes from a show-ahead source and emits them MSB
// first as fixed-length symbols whose high time encodes the bit value.
module goc_pwm_tx
    import goc_pwm_tx_pkg::*;
#(
    parameter int SPEED_W    = DEF_SPEED_W,
    parameter int UNITS_SYM  = DEF_UNITS_SYM,
    parameter int UNITS_ONE  = DEF_UNITS_ONE,
    parameter int UNITS_ZERO = DEF_UNITS_ZERO,
    parameter int STOP_UNITS = DEF_STOP_UNITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         fifo_din,
    output logic               fifo_re,
    input  logic               fifo_empty,
    input  logic               start_tx,
    input  logic [SPEED_W-1:0] base_counter,
    output logic               pwm_out,
    output logic               busy,
    output logic               tx_done
);

    localparam int UW = unit_cnt_width(UNITS_SYM, STOP_UNITS);

    localparam logic [UW-1:0]      ONE_LAST  = UW'(UNITS_ONE - 1);
    localparam logic [UW-1:0]      ZERO_LAST = UW'(UNITS_ZERO - 1);
    localparam logic [UW-1:0]      SYM_LAST  = UW'(UNITS_SYM - 1);
    localparam logic [UW-1:0]      STOP_LAST = UW'(STOP_UNITS - 1);
    localparam logic [UW-1:0]      CNT_ONE   = UW'(1);
    localparam logic [SPEED_W-1:0] LEN_ONE   = SPEED_W'(1);

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [UW-1:0]      unit_cnt_q, unit_cnt_d;
    logic [SPEED_W-1:0] unit_len_q, unit_len_d;

    logic pwm_q, pwm_d;
    logic fifo_re_q, fifo_re_d;
    logic busy_q, busy_d;
    logic tx_done_q, tx_done_d;

    logic          unit_tick;
    logic          timer_en;
    logic          timer_clear;
    logic [UW-1:0] high_last;

    assign high_last   = shift_q[7] ? ONE_LAST : ZERO_LAST;
    assign timer_en    = (state_q == ST_SYM_HIGH) || (state_q == ST_SYM_LOW) ||
                         (state_q == ST_STOP);
    assign timer_clear = (state_d != state_q);

    goc_pwm_tx_unit_timer #(
        .SPEED_W (SPEED_W)
    ) u_unit_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (timer_en),
        .clear     (timer_clear),
        .unit_len  (unit_len_q),
        .unit_tick (unit_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath: frame sequencing, bit shifting and unit counting.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        unit_cnt_d = unit_cnt_q;
        unit_len_d = unit_len_q;
        case (state_q)
            ST_IDLE: begin
                // A start with nothing queued is dropped; unit length is frozen for the frame.
                if (start_tx && !fifo_empty) begin
                    state_d    = ST_FETCH;
                    unit_len_d = (base_counter == '0) ? LEN_ONE : base_counter;
                end
            end
            ST_FETCH: begin
                shift_d    = fifo_din;
                bit_idx_d  = 3'd7;
                unit_cnt_d = '0;
                state_d    = ST_SYM_HIGH;
            end
            ST_SYM_HIGH: begin
                // The unit count carries on into the low phase so the symbol length stays fixed.
                if (unit_tick) begin
                    unit_cnt_d = unit_cnt_q + CNT_ONE;
                    if (unit_cnt_q == high_last) begin
                        state_d = ST_SYM_LOW;
                    end
                end
            end
            ST_SYM_LOW: begin
                if (unit_tick) begin
                    if (unit_cnt_q == SYM_LAST) begin
                        unit_cnt_d = '0;
                        if (bit_idx_q != 3'd0) begin
                            bit_idx_d = bit_idx_q - 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            state_d   = ST_SYM_HIGH;
                        end else if (!fifo_empty) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        unit_cnt_d = unit_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (unit_tick) begin
                    if (unit_cnt_q == STOP_LAST) begin
                        unit_cnt_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        unit_cnt_d = unit_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        pwm_d     = PWM_IDLE;
        fifo_re_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        tx_done_d = 1'b0;
        case (state_d)
            ST_FETCH:    fifo_re_d = 1'b1;
            ST_SYM_HIGH: pwm_d     = ~PWM_IDLE;
            ST_DONE:     tx_done_d = 1'b1;
            default:     pwm_d     = PWM_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            unit_cnt_q <= '0;
            unit_len_q <= LEN_ONE;
            pwm_q      <= PWM_IDLE;
            fifo_re_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            unit_cnt_q <= unit_cnt_d;
            unit_len_q <= unit_len_d;
            pwm_q      <= pwm_d;
            fifo_re_q  <= fifo_re_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign pwm_out = pwm_q;
    assign fifo_re = fifo_re_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

    // The unit counter may only return to zero together with a phase change, never by wrapping.
    assert property (@(posedge clk) disable iff (reset)
        !(unit_tick && (unit_cnt_q != '0) && (unit_cnt_d == '0) && (state_d == state_q)));

endmodule

// File: tb/tb_goc_pwm_tx.sv
// Directed bench for goc_pwm_tx: table of frames checked cycle by cycle against an
// expected waveform built from the symbol timing rules, plus a mid-frame reset sequence.
module tb_goc_pwm_tx;

    localparam int SPEED_W = 22;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         fifo_din;
    logic               fifo_re;
    logic               fifo_empty;
    logic               start_tx;
    logic [SPEED_W-1:0] base_counter;
    logic               pwm_out;
    logic               busy;
    logic               tx_done;

    goc_pwm_tx dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_din     (fifo_din),
        .fifo_re      (fifo_re),
        .fifo_empty   (fifo_empty),
        .start_tx     (start_tx),
        .base_counter (base_counter),
        .pwm_out      (pwm_out),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         base;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         chg_cycle;
        int         chg_base;
        int         pulse_cycle;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] src_q[$];
    logic [3:0] exp_q[$];   // {busy, fifo_re, pwm_out, tx_done}
    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    logic       prev_re = 1'b0;

    // Show-ahead source view of the byte queue.
    task automatic refresh_src();
        fifo_empty = (src_q.size() == 0);
        fifo_din   = fifo_empty ? 8'h00 : src_q[0];
    endtask

    // One clock: the byte strobed during the previous cycle leaves the source after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_re) begin
            checks++;
            if (src_q.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: fifo_re=1 required source non-empty, got empty");
            end else begin
                void'(src_q.pop_front());
                pops++;
            end
        end
        refresh_src();
        prev_re = fifo_re;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare one sampled cycle against the head of the expected queue.
    task automatic check_cycle(input string name, input int idx);
        logic [3:0] got;
        logic [3:0] exp;
        got = {busy, fifo_re, pwm_out, tx_done};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: {busy,re,pwm,done} got %b expected %b", name, idx, got, exp);
        end
    endtask

    // Expected waveform: per byte a 1-clk fetch, then 8 symbols of 4 units (high 3 for '1',
    // 1 for '0'), then 8 stop units low, one done cycle, then idle.
    task automatic build_exp(input vec_t v);
        int         len;
        int         h;
        logic [7:0] bb[3];
        bb[0] = v.b0;
        bb[1] = v.b1;
        bb[2] = v.b2;
        len   = (v.base == 0) ? 1 : v.base;
        exp_q.delete();
        if (v.nbytes == 0) begin
            repeat (10) exp_q.push_back(4'b0000);
        end else begin
            for (int b = 0; b < v.nbytes; b++) begin
                exp_q.push_back(4'b1100);
                for (int k = 7; k >= 0; k--) begin
                    h = bb[b][k] ? 3 : 1;
                    repeat (h * len) exp_q.push_back(4'b1010);
                    repeat ((4 - h) * len) exp_q.push_back(4'b1000);
                end
            end
            repeat (8 * len) exp_q.push_back(4'b1000);
            exp_q.push_back(4'b1001);
            repeat (3) exp_q.push_back(4'b0000);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int n;
        src_q.delete();
        if (v.nbytes > 0) src_q.push_back(v.b0);
        if (v.nbytes > 1) src_q.push_back(v.b1);
        if (v.nbytes > 2) src_q.push_back(v.b2);
        refresh_src();
        base_counter = v.base[SPEED_W-1:0];
        build_exp(v);
        pops = 0;
        n    = exp_q.size();
        for (int i = 0; i < n; i++) begin
            start_tx = (i == 0) || (i == v.pulse_cycle);
            if (i == v.chg_cycle) base_counter = v.chg_base[SPEED_W-1:0];
            tick();
            start_tx = 1'b0;
            check_cycle(v.name, i);
        end
        check_val({v.name, "_pops"}, pops, v.nbytes);
    endtask

    initial begin
        vecs[0] = '{"a5_base2",    2, 1, 8'hA5, 8'h00, 8'h00, -1, 0, -1};
        vecs[1] = '{"ff_base0",    0, 1, 8'hFF, 8'h00, 8'h00, -1, 0, -1};
        vecs[2] = '{"three_bytes", 1, 3, 8'h00, 8'h80, 8'h01, -1, 0, 40};
        vecs[3] = '{"two_base3",   3, 2, 8'h3C, 8'hC3, 8'h00, -1, 0, -1};
        vecs[4] = '{"empty_start", 2, 0, 8'h00, 8'h00, 8'h00, -1, 0, 4};
        vecs[5] = '{"midchg_5a",   2, 1, 8'h5A, 8'h00, 8'h00, 5, 5, 12};

        // Reset.
        reset        = 1'b1;
        start_tx     = 1'b0;
        base_counter = '0;
        src_q.delete();
        refresh_src();
        repeat (3) tick();
        check_val("reset_outputs", {28'd0, busy, fifo_re, pwm_out, tx_done}, 32'd0);
        reset = 1'b0;
        tick();
        check_val("idle_after_reset", {28'd0, busy, fifo_re, pwm_out, tx_done}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_vector(vecs[v]);
        end

        // Reset in the middle of a high phase aborts the frame silently.
        src_q.delete();
        src_q.push_back(8'hA5);
        refresh_src();
        base_counter = 22'd2;
        pops         = 0;
        start_tx     = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (3) tick();
        check_val("pre_reset_pwm_high", {31'd0, pwm_out}, 32'd1);
        check_val("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check_val("abort_outputs", {28'd0, busy, fifo_re, pwm_out, tx_done}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("post_abort_idle", {28'd0, busy, fifo_re, pwm_out, tx_done}, 32'd0);
        end
        check_val("abort_pops", pops, 1);

        // A fresh frame after the abort runs normally.
        run_vector(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
